// File: rtl/alu_muldiv_unit.sv
// rtl/alu_muldiv_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Pipelined multiply and restoring radix-2 divide behind a start/busy/done handshake.
module alu_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] n1,
  input  logic [DATA_W-1:0] n2,
  input  logic              cancel,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CW = $clog2(DATA_W + MUL_LAT + 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [2*DATA_W-1:0]   mul_pipe [MUL_LAT];
  logic [DATA_W-1:0]     rem, quo, dvs, dvd_orig;
  logic                  neg_q, neg_r, div0;

  logic                  idle_like, accept, signed_op;
  logic [2*DATA_W-1:0]   ext1, ext2, prod;
  logic [DATA_W-1:0]     n1_abs, n2_abs, q_fix, r_fix;
  logic [DATA_W:0]       shifted, diff;

  always_comb begin
    idle_like = (state == IDLE) || (state == DONE);
    accept    = start & ~cancel & idle_like;
    signed_op = ~op[0];
    ext1      = {{DATA_W{signed_op & n1[DATA_W-1]}}, n1};
    ext2      = {{DATA_W{signed_op & n2[DATA_W-1]}}, n2};
    prod      = ext1 * ext2;
    n1_abs    = (signed_op & n1[DATA_W-1]) ? (~n1 + 1'b1) : n1;
    n2_abs    = (signed_op & n2[DATA_W-1]) ? (~n2 + 1'b1) : n2;
    // One restoring step: shift the next dividend bit in, subtract if it fits.
    shifted   = {rem, quo[DATA_W-1]};
    diff      = shifted - {1'b0, dvs};
    q_fix     = neg_q ? (~quo + 1'b1) : quo;
    r_fix     = neg_r ? (~rem + 1'b1) : rem;
  end

  assign stall = (start & idle_like & ~cancel) | (busy & ~cancel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dvd_orig <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] <= '0;
    end else begin
      done <= 1'b0;
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];

      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              busy        <= 1'b1;
              cnt         <= '0;
              mul_pipe[0] <= prod;
              if (op[1]) begin
                state    <= DIV;
                rem      <= '0;
                quo      <= n1_abs;
                dvs      <= n2_abs;
                dvd_orig <= n1;
                neg_q    <= signed_op & (n1[DATA_W-1] ^ n2[DATA_W-1]);
                neg_r    <= signed_op & n1[DATA_W-1];
                div0     <= (n2 == '0);
              end else begin
                state <= MUL;
              end
            end else begin
              state <= IDLE;
            end
          end
          MUL: begin
            if (cnt == CW'(MUL_LAT - 1)) begin
              {hi, lo} <= mul_pipe[MUL_LAT-1];
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DIV: begin
            if (cnt == CW'(DATA_W)) begin
              // Sign-fix cycle; divide by zero bypasses the iterated result.
              hi    <= div0 ? dvd_orig : r_fix;
              lo    <= div0 ? '1 : q_fix;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
              if (!diff[DATA_W]) begin
                rem <= diff[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b1};
              end else begin
                rem <= shifted[DATA_W-1:0];
                quo <= {quo[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb/tb_alu_muldiv_unit.sv - scoreboard testbench for alu_muldiv_unit
module tb_alu_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] n1, n2, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb [$];
  logic [63:0] last;

  alu_muldiv_unit #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .n1(n1), .n2(n2),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (o)
      2'd0: return 64'(sa * sbv);
      2'd1: return ua * ub;
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(output int cyc, output bit gap);
    cyc = 0;
    gap = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        cyc = c;
        break;
      end
      if (stall !== 1'b1) gap = 1'b1;
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    n1    = a;
    n2    = b;
    sb.push_back(model(o, a, b));
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; n1 = '0; n2 = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0)
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, required all zero", hi, lo, busy, done, stall);
    if ({hi, lo, busy, done, stall} !== 67'd0) errors++;
    last = 64'd0;
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clk); hi_we = 1'b0;
    last[63:32] = 32'h12345678;
    checks++;
    if ({hi, lo} !== last) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h, required %h", hi, lo, last);
    end
    lo_we = 1'b1; wdata = 32'hCAFE0001;
    @(negedge clk); lo_we = 1'b0;
    last[31:0] = 32'hCAFE0001;
    checks++;
    if ({hi, lo} !== last) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h, required %h", hi, lo, last);
    end
  endtask

  task automatic run_table(input string name, input logic [1:0] ops [], input logic [31:0] as [], input logic [31:0] bs []);
    int cyc;
    bit gap;
    logic [63:0] exp;
    int lat;
    foreach (ops[i]) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i]);
      lat = ops[i][1] ? 34 : 3;
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL %s[%0d] stall_c0: %b, required 1", name, i, stall);
      end
      wait_done(cyc, gap);
      exp = sb.pop_front();
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL %s[%0d] latency: %0d, required %0d", name, i, cyc, lat);
      end
      checks++;
      if ({hi, lo} !== exp) begin
        errors++;
        $display("FAIL %s[%0d] result: hi=%h lo=%h, required %h", name, i, hi, lo, exp);
      end
      checks++;
      if (gap || stall !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] handshake: gap=%b stall=%b busy=%b, required 0 0 0", name, i, gap, stall, busy);
      end
      last = exp;
    end
  endtask

  task automatic test_mul;
    logic [1:0]  o [] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    logic [31:0] a [] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, $urandom, $urandom, $urandom};
    logic [31:0] b [] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, $urandom, $urandom, $urandom};
    run_table("mul", o, a, b);
  endtask

  task automatic test_div;
    logic [1:0]  o [] = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
    logic [31:0] a [] = '{32'hFFFFFFF9, 32'd100, 32'h55, 32'h80000000, 32'hFFFFFF00, 32'd7, $urandom, $urandom};
    logic [31:0] b [] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, $urandom_range(1, 5000), $urandom};
    run_table("div", o, a, b);
  endtask

  task automatic test_cancel;
    bit seen = 1'b0;
    @(negedge clk);
    issue(2'd2, 32'd1000, 32'd3);
    void'(sb.pop_back());
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) cancel = 1'b1;
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL cancel_stall: %b, required 0", stall);
    end
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_busy: %b, required 0", busy);
    end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || {hi, lo} !== last) begin
      errors++;
      $display("FAIL cancel_result: done_seen=%b hi=%h lo=%h, required 0 %h", seen, hi, lo, last);
    end
  endtask

  task automatic test_start_cancel_idle;
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'd0; n1 = 32'd3; n2 = 32'd3;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL start_cancel_stall: %b, required 0", stall);
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    if (busy === 1'b1) seen = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || {hi, lo} !== last) begin
      errors++;
      $display("FAIL start_cancel_ignored: activity=%b hi=%h lo=%h, required 0 %h", seen, hi, lo, last);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit gap;
    logic [63:0] exp;
    @(negedge clk);
    issue(2'd3, 32'd100, 32'd7);
    wait_done(cyc, gap);
    exp = sb.pop_front();
    checks++;
    if (cyc != 34 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_div: cyc=%0d hi=%h lo=%h, required 34 %h", cyc, hi, lo, exp);
    end
    issue(2'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, gap);
    exp = sb.pop_front();
    checks++;
    if (cyc != 3 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_mul: cyc=%0d hi=%h lo=%h, required 3 %h", cyc, hi, lo, exp);
    end
    last = exp;
  endtask

  task automatic test_busy_start;
    int dones = 0;
    logic [63:0] exp;
    @(negedge clk);
    issue(2'd1, 32'd1234, 32'd5678);
    @(negedge clk);
    start = 1'b1; op = 2'd3; n1 = 32'd99; n2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    exp = sb.pop_front();
    checks++;
    if (done !== 1'b1 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL busy_start_result: done=%b hi=%h lo=%h, required 1 %h", done, hi, lo, exp);
    end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL busy_start_extra_done: %0d pulses, required 0", dones);
    end
    last = exp;
  endtask

  task automatic test_write_collision;
    logic [63:0] exp;
    @(negedge clk);
    issue(2'd0, 32'd7, 32'd6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (done !== 1'b1 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL write_collision: done=%b hi=%h lo=%h, required 1 %h", done, hi, lo, exp);
    end
    last = exp;
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    @(negedge clk);
    issue(2'd2, 32'd500, 32'd9);
    void'(sb.pop_back());
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      errors++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b stall=%b, required all zero", hi, lo, busy, done, stall);
    end
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_done: done pulse after reset, required none");
    end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mul;
    test_div;
    test_cancel;
    test_start_cancel_idle;
    test_back_to_back;
    test_busy_start;
    test_write_collision;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the next generation of the execute-stage arithmetic block: it adds iterative signed/unsigned divide, pipelined multiply, a start/busy/done handshake, a pipeline stall request, and exception cancel. It sits beside the single-cycle ALU in EX. It owns HI/LO: MFHI/MFLO read them and MTHI/MTLO write them through this block.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
MUL_LAT, 2, multiply latency in pipeline stages (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request a new operation
op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
n1  in  DATA_W  rs operand (multiplicand / dividend)
n2  in  DATA_W  rt operand (multiplier / divisor)
cancel  in  1  exception flush; aborts the in-flight operation
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  DATA_W  MTHI/MTLO data
hi  out  DATA_W  HI register
lo  out  DATA_W  LO register
busy  out  1  operation in flight (registered)
done  out  1  one-cycle pulse: HI/LO just updated
stall  out  1  stall request to the pipeline

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, and all internal datapath registers cleared.
- States:
  - IDLE: start=1 and cancel=0 → MUL (op 0/1) or DIV (op 2/3); operands latched and busy=1 next cycle.
  - MUL: runs MUL_LAT cycles, then writes {hi,lo} = 2*DATA_W-bit product → DONE.
  - DIV: restoring radix-2, one quotient bit per cycle, DATA_W iterations plus 1 sign-fix cycle → DONE.
  - DONE: done=1, busy=0, for one cycle → IDLE. A new start is accepted in DONE, behaving exactly as from IDLE.
- Timing: start cycle is cycle 0; done=1 and the new hi/lo are visible in cycle MUL_LAT+1 (multiply) or DATA_W+2 (divide).
- stall = (start & state∈{IDLE,DONE} & ~cancel) | (busy & ~cancel). Stall is low in the DONE cycle so the issuing instruction advances.
- Signed multiply (op 0): two's-complement product. Unsigned multiply (op 1): zero-extended product.
- Signed divide (op 2): lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign. Most-negative/−1 gives lo=most-negative, hi=0, with no trap.
- Unsigned divide (op 3): plain unsigned quotient and remainder.
- Divide by zero (either signedness): lo = all-ones, hi = n1. Takes the full latency; no exception is raised.
- cancel=1 in any cycle: state→IDLE next cycle, busy=0, no done, hi/lo unchanged. cancel takes priority over start in the same cycle.
- hi_we/lo_we: write wdata at the next edge in any state. A write in the same cycle as a completing operation's final edge is overridden by the result; the result wins.
- start while busy (MUL/DIV): ignored. op, n1 and n2 are sampled only in the accepting cycle.
- rst mid-operation: immediate return to reset values at the next edge.

Test Plan:
- After rst, hi=0, lo=0, busy=0, stall=0. Then hi_we=1, wdata=0x12345678 → hi=0x12345678 next cycle, lo unchanged.
- MULT n1=0xFFFFFFFD (−3), n2=5, MUL_LAT=2 → done in cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall high in cycles 0–2 and low in cycle 3. MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV n1=0xFFFFFFF9 (−7), n2=2 → done in cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=0xE, hi=0x2.
- DIVU n1=0x55, n2=0 → lo=0xFFFFFFFF, hi=0x55 at cycle 34. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV started, cancel=1 at cycle 10 → busy=0 in cycle 11, no done pulse ever, hi/lo keep their prior values. Start together with cancel in IDLE → ignored, stall=0.
- Back-to-back: new MULT start asserted in the DONE cycle of a DIV → accepted; second result lands MUL_LAT+1 cycles later. A start during busy is ignored (no second done pulse).
